// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - KERNEL x KERNEL sliding-window generator over a raster pixel stream
module conv_window_gen #(
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               pix_in,
    input  logic                       pix_valid,
    output logic [KERNEL*KERNEL*N-1:0] data2conv,
    output logic                       en_out,
    output logic                       frame_done,
    output logic [CW-1:0]              col_cnt,
    output logic [RW-1:0]              row_cnt
);

    localparam int WB = KERNEL * KERNEL * N;
    localparam int LB = (KERNEL > 1) ? KERNEL - 1 : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(KERNEL - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(KERNEL - 1);

    logic [N-1:0]  win     [KERNEL][KERNEL];
    logic [N-1:0]  win_nxt [KERNEL][KERNEL];
    logic [N-1:0]  new_col [KERNEL];
    logic [WB-1:0] win_flat;
    logic          complete;
    logic          last_pix;

    // Line buffer k holds row (current - (KERNEL-1) + k); index 0 is the oldest row.
    generate
        if (KERNEL > 1) begin : g_lb
            logic [N-1:0] lb [LB][IMG_W];

            always_ff @(posedge clk) begin
                if (pix_valid) begin
                    for (int k = 0; k < LB - 1; k++) begin
                        lb[k][col_cnt] <= lb[k+1][col_cnt];
                    end
                    lb[LB-1][col_cnt] <= pix_in;
                end
            end

            always_comb begin
                for (int k = 0; k < LB; k++) begin
                    new_col[k] = lb[k][col_cnt];
                end
                new_col[KERNEL-1] = pix_in;
            end
        end else begin : g_nolb
            assign new_col[0] = pix_in;
        end
    endgenerate

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL - 1; c++) begin
                win_nxt[r][c] = win[r][c+1];
            end
            win_nxt[r][KERNEL-1] = new_col[r];
        end
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL; c++) begin
                win_flat[(r*KERNEL+c)*N +: N] = win_nxt[r][c];
            end
        end
    end

    // Only windows fully inside the current frame's rows and columns are emitted.
    assign complete = (KERNEL == 1) || ((row_cnt >= ROW_MIN) && (col_cnt >= COL_MIN));
    assign last_pix = (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            en_out     <= 1'b0;
            frame_done <= 1'b0;
            data2conv  <= '0;
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            en_out     <= 1'b0;
            frame_done <= 1'b0;
            if (pix_valid) begin
                for (int r = 0; r < KERNEL; r++) begin
                    for (int c = 0; c < KERNEL; c++) begin
                        win[r][c] <= win_nxt[r][c];
                    end
                end
                if (col_cnt == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + RW'(1);
                end else begin
                    col_cnt <= col_cnt + CW'(1);
                end
                if (complete) begin
                    en_out     <= 1'b1;
                    data2conv  <= win_flat;
                    frame_done <= last_pix;
                end
            end
        end
    end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream feeder for the convolution calculation stage.
- Accepts a raster-order pixel stream (one N-bit pixel per accepted cycle) and keeps KERNEL-1 line buffers plus a KERNEL x KERNEL window register.
- For every valid (unpadded) window position it presents a KERNEL*KERNEL*N-bit window bus with a one-cycle enable. These outputs connect directly to the calc stage's data2conv / en_in inputs.

Parameters:
- KERNEL, 3, window side; legal values 1/3/5/7.
- N, 4, pixel width in bits.
- IMG_W, 8, image width in pixels; must be >= KERNEL.
- IMG_H, 8, image height in pixels; must be >= KERNEL.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pix_in  input  N  incoming pixel, raster order (row-major, left to right).
- pix_valid  input  1  pixel accept strobe; pix_in is consumed on every cycle where it is 1.
- data2conv  output  KERNEL*KERNEL*N  window bus; element i = r*KERNEL + c occupies bits [i*N +: N]; r=0 is the top (oldest) row, c=0 is the leftmost (oldest) column.
- en_out  output  1  window valid, one cycle per window.
- frame_done  output  1  one-cycle pulse coincident with en_out of the last window of a frame.
- col_cnt  output  clog2(IMG_W)  column index of the next pixel to be accepted (debug).
- row_cnt  output  clog2(IMG_H)  row index of the next pixel to be accepted (debug).

Behaviour:
- Reset (rst=1 at posedge):
  - col_cnt, row_cnt, en_out, frame_done and data2conv all go to 0.
  - Window registers are cleared.
  - Line-buffer contents are don't-care and are not cleared.
  - Reset mid-frame abandons the frame; the next accepted pixel is treated as (0,0).
- Accept cycle (pix_valid=1):
  - Window shifts one column left: column c takes column c+1.
  - New column KERNEL-1 is {line buffer rows, oldest first, then pix_in in row KERNEL-1}.
  - Line buffers shift so each holds the previous rows at the same column.
  - col_cnt increments; at IMG_W-1 it wraps to 0 and row_cnt increments; at IMG_H-1 row_cnt wraps to 0.
- Idle cycle (pix_valid=0): counters, window and line buffers hold; en_out=0; frame_done=0; data2conv holds its last value.
- Window validity: the accepted pixel at (row,col) completes a window iff row >= KERNEL-1 and col >= KERNEL-1. No padding and no windows that straddle rows.
- Latency: data2conv and en_out are registered and appear exactly 1 cycle after the completing accept.
- Window count: (IMG_H-KERNEL+1)*(IMG_W-KERNEL+1) windows per frame.
- frame_done: asserted with the window completed by pixel (IMG_H-1, IMG_W-1).
- Back-to-back frames: pixel (0,0) of the next frame may be accepted in the cycle immediately after pixel (IMG_H-1, IMG_W-1). No bubble is required.
- Stale line-buffer data is never exposed: the first KERNEL-1 rows of every frame produce no windows.
- KERNEL=1: no line buffers; every accepted pixel yields en_out one cycle later with data2conv = pix_in.
- No backpressure: the downstream stage accepts a window every cycle.
- Pixel values pass through unmodified; no arithmetic is performed on them.

Test Plan:
- Full frame, default parameters, pix_valid held at 1, pixel(r,c) = (8r+c) mod 16:
  - exactly 36 en_out pulses; first pulse arrives 1 cycle after pixel index 18 is accepted.
  - that first window has element 0=0, element 4=9, element 8=2.
  - frame_done is high only on the 36th pulse.
- Same frame with pix_valid toggling pseudo-randomly:
  - window values and count are identical to the previous test.
  - en_out is never high in the cycle following a pix_valid=0 cycle.
  - data2conv holds between pulses.
- Two frames back-to-back, second frame's pixels = first frame's + 5 (mod 16):
  - 72 pulses in total.
  - no window of frame 2 contains frame-1 data.
  - frame_done pulses twice.
- rst asserted after 30 pixels, then a fresh full frame:
  - en_out and counters are 0 the cycle after reset.
  - the new frame yields exactly 36 correct windows.
- KERNEL=1, IMG_W=IMG_H=4: 16 pulses, each data2conv equal to the previous cycle's pix_in.
- Row boundary check, default parameters: pixels at col 0..1 of rows 2..7 produce no en_out; the window completed by pixel (3,2) has element 0 = pixel(1,0) = 8.
